seq_mul_long: RTL and testbench
===============================

// Module: seq_mul_long
// PURPOSE
//   Iterative shift-add long multiplier (UMULL/SMULL-style) in the execute path.
//   Produces 2*WIDTH-bit product as lo/hi plus destination-register tag.
//   Outputs feed the 2-word + tag clocked stage register downstream (d0=lo, d1=hi, d2=tag_out).
//   Control issues start; the pipeline stalls while busy=1.
// PARAMETERS
//   WIDTH   32  operand width; product is 2*WIDTH bits
//   WIDTH1  4   destination tag width (register address)
// PORTS
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high
//   start      in   1       request; sampled on rising edge when not busy
//   a          in   WIDTH   multiplicand (Rn)
//   b          in   WIDTH   multiplier (Rm)
//   is_signed  in   1       1=signed multiply (only honoured with SIGNED_MUL_EN)
//   tag_in     in   WIDTH1  destination tag, captured with operands
//   lo         out  WIDTH   product[WIDTH-1:0]
//   hi         out  WIDTH   product[2*WIDTH-1:WIDTH]
//   tag_out    out  WIDTH1  tag of the product on lo/hi
//   busy       out  1       1 while iterating; start ignored
//   done       out  1       one-cycle pulse: lo/hi/tag_out newly valid
// BEHAVIOUR
//   - Reset (async): state=IDLE; lo=hi=0, tag_out=0, busy=0, done=0, counter=0.
//     Reset mid-operation aborts; no done pulse; outputs return to 0.
//   - States: IDLE -> RUN on start; RUN -> DONE after WIDTH iterations;
//     DONE -> RUN if start, else IDLE. DONE lasts exactly one cycle.
//   - Accept: start=1 at edge k in IDLE or DONE. Latch a, b, tag_in, is_signed.
//     Clear accumulator and counter. busy=1 from edge k.
//   - Iterate: edges k+1..k+WIDTH, one multiplier bit per edge, LSB first.
//     If bit=1, add multiplicand to the upper accumulator (WIDTH+1 bits, keeps carry).
//     Shift {carry,acc,mplier} right by one. Counter counts 0..WIDTH-1.
//   - Complete: edge k+WIDTH writes lo/hi/tag_out, state=DONE, busy=0.
//     done=1 for the cycle after that edge. Latency = WIDTH cycles accept->done.
//   - lo/hi/tag_out change only when entering DONE; held through IDLE and RUN.
//   - start while busy=1: ignored, no side effects, not queued.
//   - start during DONE cycle: accepted (back-to-back); done drops next cycle, busy=1.
//   - Arithmetic: unsigned product exact, no overflow.
//     0 operand -> 0. No early termination; latency fixed.
// CONFIGURATION
//   SIGNED_MUL_EN defined:
//     - If is_signed=1, operands are taken as two's complement.
//     - Magnitudes are multiplied; the 2*WIDTH result is negated on the final edge
//       if the operand signs differ.
//     - Most-negative operand handled: magnitude fits in WIDTH bits unsigned.
//     - Latency unchanged.
//   SIGNED_MUL_EN undefined:
//     - is_signed is ignored; all multiplies are unsigned; no negate logic.
// TESTING
//   1. a=3, b=5, tag_in=4'h7: done exactly 32 cycles after accept;
//      lo=0x0000000F, hi=0, tag_out=7.
//   2. a=b=0xFFFFFFFF: lo=0x00000001, hi=0xFFFFFFFE; busy=1 for exactly 32 cycles.
//   3. Accept a=2, b=2; pulse start with a=9 at cycle 10 of the run:
//      result lo=4, exactly one done pulse.
//   4. Assert reset at cycle 15 of a=7, b=7:
//      busy=0, done never pulses, lo=hi=tag_out=0; next start a=7, b=7 -> lo=49.
//   5. start held high through the done cycle with new a=6, b=7, tag=2:
//      first result presented, then lo=42, tag_out=2 exactly 32 cycles later.
//   6. a=0xFFFFFFFE, b=3, is_signed=1:
//      with SIGNED_MUL_EN {hi,lo}=0xFFFFFFFF_FFFFFFFA;
//      without it {hi,lo}=0x00000002_FFFFFFFA.

Source files
------------

// File: rtl/seq_mul_long.sv
// Iterative shift-add long multiplier: WIDTH cycles from accept to done, product on lo/hi with tag.
// Optional two's-complement support is enabled by defining SIGNED_MUL_EN.
module seq_mul_long #(
  parameter int WIDTH  = 32,
  parameter int WIDTH1 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              is_signed,
  input  logic [WIDTH1-1:0] tag_in,
  output logic [WIDTH-1:0]  lo,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH1-1:0] tag_out,
  output logic              busy,
  output logic              done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    mplier;
  logic [CW-1:0]       cnt;
  logic [WIDTH1-1:0]   tag_r;
  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  prod;
  logic [2*WIDTH-1:0]  result;
  logic [WIDTH-1:0]    a_op;
  logic [WIDTH-1:0]    b_op;

  // One partial product per cycle; the carry lands in sum[WIDTH] before the shift.
  always_comb begin
    sum  = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    prod = {sum, mplier[WIDTH-1:1]};
  end

`ifdef SIGNED_MUL_EN
  logic neg;
  logic neg_op;

  // Magnitudes are multiplied unsigned; the most-negative value's magnitude still fits.
  always_comb begin
    neg_op = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    a_op   = (is_signed && a[WIDTH-1]) ? -a : a;
    b_op   = (is_signed && b[WIDTH-1]) ? -b : b;
    result = neg ? -prod : prod;
  end
`else
  logic unused_is_signed;

  always_comb begin
    a_op             = a;
    b_op             = b;
    result           = prod;
    unused_is_signed = is_signed;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lo      <= '0;
      hi      <= '0;
      tag_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      tag_r   <= '0;
`ifdef SIGNED_MUL_EN
      neg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= a_op;
            mplier <= b_op;
            tag_r  <= tag_in;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SIGNED_MUL_EN
            neg    <= neg_op;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            lo      <= result[WIDTH-1:0];
            hi      <= result[2*WIDTH-1:WIDTH];
            tag_out <= tag_r;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_long.sv
// Scoreboard bench for seq_mul_long: directed vectors, expected results queued at issue
// and checked by an independent monitor on every done pulse.
module tb_seq_mul_long;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        is_signed;
  logic [3:0]  tag_in;
  logic [31:0] lo, hi;
  logic [3:0]  tag_out;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  logic [67:0] sb[$];

  seq_mul_long #(.WIDTH(32), .WIDTH1(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .is_signed(is_signed), .tag_in(tag_in), .lo(lo), .hi(hi),
    .tag_out(tag_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got tag=%0h hi=%08h lo=%08h, expected no result", tag_out, hi, lo);
      end else begin
        logic [67:0] e;
        e = sb.pop_front();
        if ({tag_out, hi, lo} !== e) begin
          errors++;
          $display("FAIL result: got tag=%0h hi=%08h lo=%08h, expected tag=%0h hi=%08h lo=%08h",
                   tag_out, hi, lo, e[67:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Present operands and pulse start across one edge; leaves time at edge+1.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] tv,
                       input logic sv, input logic push, input logic [63:0] expv);
    a = av; b = bv; tag_in = tv; is_signed = sv; start = 1'b1;
    if (push) sb.push_back({tv, expv});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called at accept edge+1; returns edges until done is seen and cycles with busy high.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) return;
      if (busy) bcnt++;
    end
    checks++;
    errors++;
    $display("FAIL timeout: done not seen within 100 cycles, expected done");
  endtask

  int lat, bcnt;

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_hi_tag", {28'd0, tag_out, hi}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: 3*5, fixed latency
    issue(32'd3, 32'd5, 4'h7, 1'b0, 1'b1, 64'd15);
    check("t1_busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done(lat, bcnt);
    check("t1_latency", 64'(lat), 64'd32);
    repeat (2) @(posedge clk); #1;

    // 2: all-ones squared, busy width
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 1'b0, 1'b1, 64'hFFFF_FFFE_0000_0001);
    wait_done(lat, bcnt);
    check("t2_busy_cycles", 64'(bcnt), 64'd32);
    check("t2_latency", 64'(lat), 64'd32);
    @(posedge clk); #1;

    // 3: start pulse mid-run is ignored
    issue(32'd2, 32'd2, 4'h1, 1'b0, 1'b1, 64'd4);
    repeat (9) @(posedge clk);
    #1;
    a = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t3_pending_results", 64'(sb.size()), 64'd0);

    // 4: reset mid-operation aborts
    issue(32'd7, 32'd7, 4'h5, 1'b0, 1'b0, 64'd0);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t4_busy_done_in_reset", {62'd0, busy, done}, 64'd0);
    check("t4_outputs_cleared", {28'd0, tag_out, hi} | {32'd0, lo}, 64'd0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t4_idle_after_abort", {62'd0, busy, done}, 64'd0);
    issue(32'd7, 32'd7, 4'h5, 1'b0, 1'b1, 64'd49);
    wait_done(lat, bcnt);
    @(posedge clk); #1;

    // 5: start held through done cycle -> back-to-back
    issue(32'd10, 32'd11, 4'h1, 1'b0, 1'b1, 64'd110);
    a = 32'd6; b = 32'd7; tag_in = 4'h2; start = 1'b1;
    sb.push_back({4'h2, 64'd42});
    wait_done(lat, bcnt);
    check("t5_first_latency", 64'(lat), 64'd32);
    @(posedge clk); #1;
    start = 1'b0;
    check("t5_b2b_busy_done", {62'd0, busy, done}, 64'd2);
    wait_done(lat, bcnt);
    check("t5_second_latency", 64'(lat), 64'd32);
    @(posedge clk); #1;

    // 6: signed request, result depends on build option
`ifdef SIGNED_MUL_EN
    issue(32'hFFFF_FFFE, 32'd3, 4'h9, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    wait_done(lat, bcnt);
    @(posedge clk); #1;
    issue(32'h8000_0000, 32'd2, 4'hA, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0000);
`else
    issue(32'hFFFF_FFFE, 32'd3, 4'h9, 1'b1, 1'b1, 64'h0000_0002_FFFF_FFFA);
    wait_done(lat, bcnt);
    @(posedge clk); #1;
    issue(32'h8000_0000, 32'd2, 4'hA, 1'b1, 1'b1, 64'h0000_0001_0000_0000);
`endif
    wait_done(lat, bcnt);
    @(posedge clk); #1;

    // zero operand and a generic pattern
    issue(32'd0, 32'h1234_5678, 4'hB, 1'b0, 1'b1, 64'd0);
    wait_done(lat, bcnt);
    @(posedge clk); #1;
    issue(32'h1234_5678, 32'h0000_0100, 4'hC, 1'b0, 1'b1, 64'h0000_0012_3456_7800);
    wait_done(lat, bcnt);
    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
